// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational ALU between NUM_REQ requesters. A round-robin
// arbiter picks one pending request while idle. The winner's operands are
// registered onto the ALU inputs. The ALU result is captured one cycle later
// and returned, together with the requester index, on a response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A requester holds req_valid and
// its operands stable until it sees its req_ready bit. The controller holds
// resp_valid, resp_data, resp_id and resp_err stable until resp_ready.
//
// Optional feature, compile-time macro ALU_SHARE_CTRL_OPCHECK_EN:
//   defined   - an opcode above MAX_OP is still accepted. It is sent to the
//               ALU as 0, and its response carries resp_data = 0 and
//               resp_err = 1.
//   undefined - the opcode passes through unchanged and resp_err is tied 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready one-hot or 0)
//   req_a/b/sel       packed operands; requester i owns slice i
//   resp_valid/ready  response handshake
//   resp_data/id/err  result, owning requester index, illegal-opcode flag
//   alu_a/b/sel       registered ALU inputs
//   alu_y             ALU result
//   busy              high whenever the FSM is not IDLE
//   state_dbg         current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4,
    parameter int SEL_W   = 3,
    parameter int MAX_OP  = 4,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0] req_sel,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_err,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [SEL_W-1:0]         alu_sel,
    input  logic [WIDTH-1:0]         alu_y,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] next_ptr;
    logic [SEL_W-1:0] sel_in;

    assign state_dbg = state;

    // Round-robin search: the first valid requester at or above rr_ptr,
    // wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign next_ptr = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign sel_in   = req_sel[gnt_idx*SEL_W +: SEL_W];

    // The request is accepted in the same cycle it is seen while idle. The
    // ready is masked during reset so that every output reads 0 then.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef ALU_SHARE_CTRL_OPCHECK_EN
    logic sel_bad;
    logic err_q;

    assign sel_bad = (sel_in > SEL_W'(MAX_OP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if ((state == IDLE) && gnt_found) begin
                err_q <= sel_bad;
            end
            if (state == EXEC) begin
                resp_err <= err_q;
            end
        end
    end
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        // ALU inputs change only here, so they stay stable
                        // for the whole operation.
                        alu_a  <= req_a[gnt_idx*WIDTH +: WIDTH];
                        alu_b  <= req_b[gnt_idx*WIDTH +: WIDTH];
`ifdef ALU_SHARE_CTRL_OPCHECK_EN
                        alu_sel <= sel_bad ? '0 : sel_in;
`else
                        alu_sel <= sel_in;
`endif
                        id_q   <= gnt_idx;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ALU_SHARE_CTRL_OPCHECK_EN
                    resp_data <= err_q ? '0 : alu_y;
`else
                    resp_data <= alu_y;
`endif
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // resp_data/resp_id keep their values after the handshake.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
